// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime behind a
// simple req/ack bus, plus the machine-level pending vector for the CSR block.
module clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        ack,
    output logic [63:0] rdata,
    output logic        err,
    input  logic        ext_irq,
    output logic [63:0] out_time,
    output logic [63:0] out_ip
);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
    localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
    localparam logic [15:0] PRESC_LAST    = 16'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        accept_s;
    logic        sel_msip_s, sel_cmp_s, sel_time_s, addr_ok_s;
    logic        wr_msip_s, wr_cmp_s, wr_time_s;
    logic        tick_s;
    logic        mtip_s;
    logic [63:0] rd_val_s;

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        msip_r;
    logic        meip_meta_r, meip_sync_r;
    logic        ack_r, err_r;
    logic [63:0] rdata_r;

    // Replace only the byte lanes whose strobe is set; others keep old_val.
    function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Bus FSM next state: accept in IDLE, always spend exactly one cycle in RESP.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Address decode, write enables and read mux; misaligned offsets never match.
    always_comb begin
        sel_msip_s = (addr == ADDR_MSIP);
        sel_cmp_s  = (addr == ADDR_MTIMECMP);
        sel_time_s = (addr == ADDR_MTIME);
        addr_ok_s  = sel_msip_s | sel_cmp_s | sel_time_s;
        wr_msip_s  = accept_s & we & sel_msip_s;
        wr_cmp_s   = accept_s & we & sel_cmp_s;
        wr_time_s  = accept_s & we & sel_time_s;
        if (sel_msip_s) begin
            rd_val_s = {63'd0, msip_r};
        end else if (sel_cmp_s) begin
            rd_val_s = mtimecmp_r;
        end else if (sel_time_s) begin
            rd_val_s = mtime_r;
        end else begin
            rd_val_s = 64'd0;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);
    assign mtip_s = (mtime_r >= mtimecmp_r);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prescaler and mtime; a bus write to mtime suppresses that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 16'd0;
            mtime_r <= 64'd0;
        end else begin
            presc_r <= tick_s ? 16'd0 : (presc_r + 16'd1);
            if (wr_time_s) begin
                mtime_r <= merge_lanes(mtime_r, wdata, wstrb);
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
        end
    end

    // Software-writable registers: mtimecmp (byte lanes) and msip (lane 0, bit 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r     <= 1'b0;
        end else begin
            if (wr_cmp_s) begin
                mtimecmp_r <= merge_lanes(mtimecmp_r, wdata, wstrb);
            end
            if (wr_msip_s && wstrb[0]) begin
                msip_r <= wdata[0];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous external interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meip_meta_r <= 1'b0;
            meip_sync_r <= 1'b0;
        end else begin
            meip_meta_r <= ext_irq;
            meip_sync_r <= meip_meta_r;
        end
    end

    // Response registers: captured at accept so reads see pre-write values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 64'd0;
        end else begin
            ack_r   <= accept_s;
            err_r   <= accept_s & ~addr_ok_s;
            rdata_r <= (accept_s && addr_ok_s && !we) ? rd_val_s : 64'd0;
        end
    end

    assign ack      = ack_r;
    assign err      = err_r;
    assign rdata    = rdata_r;
    assign out_time = mtime_r;
    assign out_ip   = {52'd0, meip_sync_r, 3'd0, mtip_s, 3'd0, msip_r, 3'd0};

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint (TICK_DIV=1 main instance, TICK_DIV=4 timer-only instance).
module tb_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        ack, err;
    logic [63:0] rdata;
    logic        ext_irq;
    logic [63:0] out_time, out_ip;

    logic        req4, we4, ext_irq4;
    logic [15:0] addr4;
    logic [63:0] wdata4;
    logic [7:0]  wstrb4;
    logic        ack4, err4;
    logic [63:0] rdata4, out_time4, out_ip4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clint #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ack(ack), .rdata(rdata), .err(err), .ext_irq(ext_irq),
        .out_time(out_time), .out_ip(out_ip)
    );

    clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
        .wstrb(wstrb4), .ack(ack4), .rdata(rdata4), .err(err4), .ext_irq(ext_irq4),
        .out_time(out_time4), .out_ip(out_ip4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus access: request before an edge, expect ack right after it and gone one cycle later.
    task automatic bus(input logic w, input logic [15:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd, output logic er);
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
        step();
        req = 1'b0;
        rd = rdata;
        er = err;
        n_vec++;
        if (ack !== 1'b1) begin
            n_bad++;
            $display("FAIL bus_ack addr=%h: got %b, want 1", a, ack);
        end
        step();
        n_vec++;
        if (ack !== 1'b0) begin
            n_bad++;
            $display("FAIL bus_ack_one_cycle addr=%h: got %b, want 0", a, ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if ({ack, err, rdata, out_time, out_ip} !== {1'b0, 1'b0, 64'd0, 64'd0, 64'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h time=%h ip=%h, want all 0",
                     ack, err, rdata, out_time, out_ip);
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) begin
                n_vec++;
                if (out_time4 !== 64'd0) begin
                    n_bad++;
                    $display("FAIL div4_first_tick_early: got %h, want 0", out_time4);
                end
            end
            if (i == 4) begin
                n_vec++;
                if (out_time4 !== 64'd1) begin
                    n_bad++;
                    $display("FAIL div4_first_tick: got %h, want 1", out_time4);
                end
            end
        end
        n_vec++;
        if (out_time !== 64'd10 || out_ip !== 64'd0) begin
            n_bad++;
            $display("FAIL idle10: got time=%h ip=%h, want time=a ip=0", out_time, out_ip);
        end
    endtask

    task automatic test_mtimecmp();
        logic [63:0] rd;
        logic        er;
        bit          hit;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (out_time == 64'h10) hit = 1'b1;
            else step();
        end
        bus(1'b1, 16'h4000, 64'h20, 8'hFF, rd, er);
        n_vec++;
        if (er !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_write_err: got %b, want 0", er);
        end
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (out_time == 64'h1F) hit = 1'b1;
            else step();
        end
        n_vec++;
        if (!hit || out_ip[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL mtip_below: got time=%h mtip=%b, want time=1f mtip=0", out_time, out_ip[7]);
        end
        step();
        n_vec++;
        if (out_time !== 64'h20 || out_ip[7] !== 1'b1) begin
            n_bad++;
            $display("FAIL mtip_reach: got time=%h mtip=%b, want time=20 mtip=1", out_time, out_ip[7]);
        end
        bus(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (rd !== 64'h20 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_read: got %h err=%b, want 20 err=0", rd, er);
        end
        req = 1'b1; we = 1'b1; addr = 16'h4000; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF;
        step();
        req = 1'b0;
        n_vec++;
        if (ack !== 1'b1 || out_ip[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL mtip_clear: got ack=%b mtip=%b, want ack=1 mtip=0", ack, out_ip[7]);
        end
        step();
    endtask

    task automatic test_mtime_wrap();
        logic [63:0] rd;
        logic        er;
        logic [63:0] exp_t [4];
        exp_t[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        exp_t[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_t[2] = 64'h0;
        exp_t[3] = 64'h1;
        req = 1'b1; we = 1'b1; addr = 16'hBFF8; wdata = 64'hFFFF_FFFF_FFFF_FFFE; wstrb = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            req = 1'b0;
            n_vec++;
            if (out_time !== exp_t[i]) begin
                n_bad++;
                $display("FAIL wrap_step%0d: got %h, want %h", i, out_time, exp_t[i]);
            end
        end
        bus(1'b1, 16'hBFF8, 64'h1122_3344_5566_7700, 8'hFF, rd, er);
        req = 1'b1; we = 1'b1; addr = 16'hBFF8; wdata = 64'h0000_0000_0000_AB00; wstrb = 8'h02;
        step();
        req = 1'b0;
        n_vec++;
        if (out_time !== 64'h1122_3344_5566_AB01) begin
            n_bad++;
            $display("FAIL time_lane_write: got %h, want 1122334455 66ab01", out_time);
        end
        step();
    endtask

    task automatic test_msip();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 16'h0000, 64'h3, 8'h01, rd, er);
        n_vec++;
        if (out_ip[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL msip_set: got %b, want 1", out_ip[3]);
        end
        bus(1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (rd !== 64'h1 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL msip_read: got %h err=%b, want 1 err=0", rd, er);
        end
        bus(1'b1, 16'h0000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (out_ip[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL msip_nostrb: got %b, want 1", out_ip[3]);
        end
        bus(1'b1, 16'h0000, 64'd0, 8'h01, rd, er);
        n_vec++;
        if (out_ip[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL msip_clear: got %b, want 0", out_ip[3]);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd;
        logic        er;
        bus(1'b0, 16'h1000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_bad++;
            $display("FAIL err_unmapped: got err=%b rd=%h, want err=1 rd=0", er, rd);
        end
        bus(1'b0, 16'h4004, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_bad++;
            $display("FAIL err_misaligned: got err=%b rd=%h, want err=1 rd=0", er, rd);
        end
        bus(1'b1, 16'h4004, 64'd0, 8'hFF, rd, er);
        n_vec++;
        if (er !== 1'b1) begin
            n_bad++;
            $display("FAIL err_write: got %b, want 1", er);
        end
        bus(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
            n_bad++;
            $display("FAIL err_no_side_effect: got %h err=%b, want ffffffffffffffff err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack;
        exp_ack = 4'b0101;
        req = 1'b1; we = 1'b0; addr = 16'h4000; wdata = 64'd0; wstrb = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) req = 1'b0;
            n_vec++;
            if (ack !== exp_ack[i]) begin
                n_bad++;
                $display("FAIL b2b_ack_cycle%0d: got %b, want %b", i, ack, exp_ack[i]);
            end
        end
        step();
    endtask

    task automatic test_ext_irq();
        bit seen;
        ext_irq = 1'b1;
        n_vec++;
        if (out_ip[11] !== 1'b0) begin
            n_bad++;
            $display("FAIL meip_not_comb: got %b, want 0", out_ip[11]);
        end
        seen = 1'b0;
        for (int k = 1; k <= 3 && !seen; k++) begin
            step();
            if (out_ip[11] === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL meip_rise: got %b, want 1 within 3 cycles", out_ip[11]);
        end
        step();
        step();
        ext_irq = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 3 && !seen; k++) begin
            step();
            if (out_ip[11] === 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL meip_fall: got %b, want 0 within 3 cycles", out_ip[11]);
        end
    endtask

    task automatic test_tick_div4();
        logic [63:0] v;
        logic [63:0] want;
        bit          moved;
        v = out_time4;
        moved = 1'b0;
        for (int k = 0; k < 8 && !moved; k++) begin
            step();
            if (out_time4 !== v) moved = 1'b1;
        end
        n_vec++;
        if (!moved) begin
            n_bad++;
            $display("FAIL div4_no_tick: got %h, want change within 8 cycles", out_time4);
        end
        v = out_time4;
        for (int r = 0; r < 2; r++) begin
            for (int j = 1; j <= 4; j++) begin
                step();
                want = (j == 4) ? (v + 64'd1) : v;
                n_vec++;
                if (out_time4 !== want) begin
                    n_bad++;
                    $display("FAIL div4_period r%0d j%0d: got %h, want %h", r, j, out_time4, want);
                end
            end
            v = v + 64'd1;
        end
        n_vec++;
        if ({ack4, err4, rdata4, out_ip4} !== {1'b0, 1'b0, 64'd0, 64'd0}) begin
            n_bad++;
            $display("FAIL div4_quiet: got ack=%b err=%b rd=%h ip=%h, want all 0",
                     ack4, err4, rdata4, out_ip4);
        end
    endtask

    task automatic test_reset_in_resp();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 16'h0000, 64'h1, 8'h01, rd, er);
        bus(1'b1, 16'h4000, 64'h5, 8'hFF, rd, er);
        req = 1'b1; we = 1'b0; addr = 16'h4000; wdata = 64'd0; wstrb = 8'h00;
        step();
        rst = 1'b1;
        req = 1'b0;
        #1;
        n_vec++;
        if ({ack, err, rdata, out_time, out_ip, out_time4} !== {1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0}) begin
            n_bad++;
            $display("FAIL rst_in_resp: got ack=%b err=%b rd=%h time=%h ip=%h, want all 0",
                     ack, err, rdata, out_time, out_ip);
        end
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (ack !== 1'b0 || out_time !== 64'd1) begin
            n_bad++;
            $display("FAIL rst_dropped_txn: got ack=%b time=%h, want ack=0 time=1", ack, out_time);
        end
        bus(1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (rd !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_msip: got %h, want 0", rd);
        end
        bus(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
        n_vec++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL rst_mtimecmp: got %h, want ffffffffffffffff", rd);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 64'd0; wstrb = 8'h00;
        ext_irq = 1'b0;
        req4 = 1'b0; we4 = 1'b0; addr4 = 16'h0000; wdata4 = 64'd0; wstrb4 = 8'h00;
        ext_irq4 = 1'b0;
        test_reset();
        test_mtimecmp();
        test_mtime_wrap();
        test_msip();
        test_errors();
        test_back_to_back();
        test_ext_irq();
        test_tick_div4();
        test_reset_in_resp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
